rr_arb4_onehot: RTL and testbench

RR_ARB4_ONEHOT -- requirements
Module: rr_arb4_onehot

---
 rtl/rr_arb4_onehot.sv | 154 +++++++++++++++
 tb/tb_rr_arb4_onehot.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_onehot.sv
// Four-way round-robin arbiter with a registered one-hot grant and a rotating priority pointer.
// Optional grant-hold timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_arb4_onehot #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  // "release" is a reserved word, so the owner's release pulse is named release_pulse.
  input  logic       release_pulse,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nxt;
  logic       r_grant_valid;
  logic [1:0] w_owner;
  logic       w_drop;

  // First asserted request scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] rq, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && rq[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [1:0] f_encode(input logic [3:0] oh);
    case (oh)
      4'b0001: f_encode = 2'd0;
      4'b0010: f_encode = 2'd1;
      4'b0100: f_encode = 2'd2;
      4'b1000: f_encode = 2'd3;
      default: f_encode = 2'd0;
    endcase
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  // Hold counter: zero on entry to OWNED, counts every OWNED cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_OWNED) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  // Timeout pulse register, aligned with the grant dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign w_owner = f_encode(r_grant);
  assign w_drop  = release_pulse | ~(|(req & r_grant));

  // Next-state, pointer and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
`ifdef ARB_TIMEOUT_EN
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_grant_nxt = 4'b0001 << f_rr_pick(req, r_ptr);
          w_state_nxt = S_OWNED;
        end else begin
          w_grant_nxt = 4'b0000;
        end
      end
      S_OWNED: begin
        // Release beats a coincident expiry, so the timeout pulse stays low then.
        if (w_drop) begin
          w_grant_nxt = 4'b0000;
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_owner + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == LP_LAST) begin
          w_grant_nxt   = 4'b0000;
          w_state_nxt   = S_IDLE;
          w_ptr_nxt     = w_owner + 2'd1;
          w_timeout_nxt = 1'b1;
        end
`endif
        else begin
          w_grant_nxt = r_grant;
        end
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= 2'd0;
      r_grant       <= 4'b0000;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_arb4_onehot.sv
// Self-checking bench for rr_arb4_onehot: directed scenarios plus a per-cycle behavioural model.
module tb_rr_arb4_onehot;

  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    int owner;   // -1 when nobody owns the grant
    int ptr;
    int hold;    // cycles already spent owning
    bit to;
  } model_t;

  model_t m;

  rr_arb4_onehot #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .release_pulse(rel),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level arbitration rule: one owner at a time, rotate priority past the last owner.
  function automatic model_t model_next(input model_t cur, input logic [3:0] rq, input logic rl);
    model_t n;
    n    = cur;
    n.to = 1'b0;
    if (cur.owner < 0) begin
      for (int k = 3; k >= 0; k--) begin
        if (rq[(cur.ptr + k) % 4]) begin
          n.owner = (cur.ptr + k) % 4;
          n.hold  = 0;
        end
      end
    end else if (rl || !rq[cur.owner]) begin
      n.ptr   = (cur.owner + 1) % 4;
      n.owner = -1;
    end else if (TO_EN && (cur.hold + 1 == TO)) begin
      n.ptr   = (cur.owner + 1) % 4;
      n.owner = -1;
      n.to    = 1'b1;
    end else begin
      n.hold = cur.hold + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] model_grant(input model_t s);
    if (s.owner < 0) return 4'b0000;
    return 4'(1 << s.owner);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{owner: -1, ptr: 0, hold: 0, to: 1'b0};
    end else begin
      m <= model_next(m, req, rel);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_grant", {28'd0, grant}, {28'd0, model_grant(m)});
      chk("cyc_timeout", {31'd0, timeout}, {31'd0, m.to});
      chk("cyc_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      chk("cyc_valid", {31'd0, grant_valid}, {31'd0, |grant});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;
    #1;
    chk("rst_grant", {28'd0, grant}, 32'h0);
    chk("rst_valid", {31'd0, grant_valid}, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);

    // Basic grant, release, ptr skips bit0.
    do_reset();
    req = 4'b0101;
    @(negedge clk); chk("s1_first", {28'd0, grant}, 32'h1); rel = 1'b1;
    @(negedge clk); chk("s1_gap", {28'd0, grant}, 32'h0); rel = 1'b0;
    @(negedge clk); chk("s1_rot", {28'd0, grant}, 32'h4); rel = 1'b1;
    @(negedge clk); rel = 1'b0; req = 4'b0000;
    @(negedge clk); chk("s1_idle", {28'd0, grant}, 32'h0);
    // Release in IDLE is ignored: bit2 still gets granted.
    req = 4'b0100; rel = 1'b1;
    @(negedge clk); chk("s1_rel_idle", {28'd0, grant}, 32'h4); rel = 1'b0; req = 4'b0000;
    @(negedge clk);

    // Full rotation with all requesters active, including the 3 -> 0 wrap.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s2_rot", {28'd0, grant}, 32'(1 << (k % 4)));
      rel = 1'b1;
      @(negedge clk);
      chk("s2_gap", {28'd0, grant}, 32'h0);
      rel = 1'b0;
    end
    req = 4'b0000;

    // Owner holds while others change, then drops its request.
    do_reset();
    req = 4'b0010;
    @(negedge clk); chk("s3_grant", {28'd0, grant}, 32'h2); req = 4'b0111;
    @(negedge clk); chk("s3_hold", {28'd0, grant}, 32'h2); req = 4'b1101;
    @(negedge clk); chk("s3_drop", {28'd0, grant}, 32'h0);
    @(negedge clk); chk("s3_next", {28'd0, grant}, 32'h4); req = 4'b0000;
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle while owning.
    do_reset();
    req = 4'b1000;
    @(negedge clk); chk("s4_grant", {28'd0, grant}, 32'h8);
    #2; rst_n = 1'b0; #1;
    chk("s4_async_grant", {28'd0, grant}, 32'h0);
    chk("s4_async_valid", {31'd0, grant_valid}, 32'h0);
    chk("s4_async_to", {31'd0, timeout}, 32'h0);
    @(negedge clk); req = 4'b1001; rst_n = 1'b1;
    @(negedge clk); chk("s4_restart", {28'd0, grant}, 32'h1); req = 4'b0000;
    @(negedge clk);

    // Grant-hold limit with a single persistent requester.
    do_reset();
    req = 4'b0010;
    if (TO_EN) begin
      for (int k = 0; k < TO; k++) begin
        @(negedge clk); chk("s5_hold", {28'd0, grant}, 32'h2);
      end
      @(negedge clk);
      chk("s5_drop", {28'd0, grant}, 32'h0);
      chk("s5_pulse", {31'd0, timeout}, 32'h1);
      @(negedge clk);
      chk("s5_regrant", {28'd0, grant}, 32'h2);
      chk("s5_pulse_end", {31'd0, timeout}, 32'h0);
      // Release coinciding with expiry wins; no timeout pulse.
      for (int k = 0; k < TO - 1; k++) @(negedge clk);
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      chk("s5_rel_wins", {28'd0, grant}, 32'h0);
      chk("s5_rel_no_to", {31'd0, timeout}, 32'h0);
    end else begin
      repeat (110) @(negedge clk);
      chk("s5_forever", {28'd0, grant}, 32'h2);
      chk("s5_no_to", {31'd0, timeout}, 32'h0);
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
